rotary_step_decoder: RTL and testbench



---
 rtl/rotary_pkg.sv | 26 ++
 rtl/debounce_filter.sv | 53 +++++
 rtl/rotary_step_decoder.sv | 139 +++++++++++++
 tb/tb_rotary_step_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder decoder: FSM encoding, direction
// constants and the default debounce length.
package rotary_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6,
        ST_ERR  = 3'd7
    } rot_state_e;

    // The count never exceeds cycles-1, so clog2(cycles) bits suffice.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One raw input: 2-flop synchronizer followed by a consecutive-difference
// counter that moves the filtered bit only after a stable run.
module debounce_filter
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synchronized value agrees restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rotary_step_decoder.sv
// Rotary encoder front end: debounced quadrature decoding into detent steps,
// push-switch press pulses and an 8-bit position counter.
module rotary_step_decoder
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       ROT_A,
    input  logic       ROT_B,
    input  logic       ROT_CENTER,
    output logic       STEP,
    output logic       DIR,
    output logic       PRESS,
    output logic [7:0] POS,
    output rot_state_e dbg_state_o
);

    logic filt_a;
    logic filt_b;
    logic filt_c;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
        .clk_i(CLK_IN), .rst_i(RST_IN), .raw_i(ROT_A), .filt_o(filt_a)
    );
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
        .clk_i(CLK_IN), .rst_i(RST_IN), .raw_i(ROT_B), .filt_o(filt_b)
    );
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_c (
        .clk_i(CLK_IN), .rst_i(RST_IN), .raw_i(ROT_CENTER), .filt_o(filt_c)
    );

    rot_state_e state_q, state_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       press_q, press_d;
    logic       center_prev_q;
    logic [7:0] pos_q, pos_d;
    logic [1:0] ab;

    assign ab = {filt_a, filt_b};

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q       <= ST_IDLE;
            step_q        <= 1'b0;
            dir_q         <= DIR_CCW;
            press_q       <= 1'b0;
            center_prev_q <= 1'b0;
            pos_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            dir_q         <= dir_d;
            press_q       <= press_d;
            center_prev_q <= filt_c;
            pos_q         <= pos_d;
        end
    end

    // Each state remembers the last AB code; backtracking one code steps back.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: case (ab)
                2'b10:   state_d = ST_CW1;
                2'b01:   state_d = ST_CCW1;
                2'b11:   state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
            ST_CW1: case (ab)
                2'b11:   state_d = ST_CW2;
                2'b00:   state_d = ST_IDLE;
                2'b01:   state_d = ST_ERR;
                default: state_d = ST_CW1;
            endcase
            ST_CW2: case (ab)
                2'b01:   state_d = ST_CW3;
                2'b10:   state_d = ST_CW1;
                2'b00:   state_d = ST_ERR;
                default: state_d = ST_CW2;
            endcase
            ST_CW3: case (ab)
                2'b00: begin
                    state_d = ST_IDLE;
                    step_d  = 1'b1;
                    dir_d   = DIR_CW;
                end
                2'b11:   state_d = ST_CW2;
                2'b10:   state_d = ST_ERR;
                default: state_d = ST_CW3;
            endcase
            ST_CCW1: case (ab)
                2'b11:   state_d = ST_CCW2;
                2'b00:   state_d = ST_IDLE;
                2'b10:   state_d = ST_ERR;
                default: state_d = ST_CCW1;
            endcase
            ST_CCW2: case (ab)
                2'b10:   state_d = ST_CCW3;
                2'b01:   state_d = ST_CCW1;
                2'b00:   state_d = ST_ERR;
                default: state_d = ST_CCW2;
            endcase
            ST_CCW3: case (ab)
                2'b00: begin
                    state_d = ST_IDLE;
                    step_d  = 1'b1;
                    dir_d   = DIR_CCW;
                end
                2'b11:   state_d = ST_CCW2;
                2'b01:   state_d = ST_ERR;
                default: state_d = ST_CCW3;
            endcase
            default: state_d = (ab == 2'b00) ? ST_IDLE : ST_ERR;
        endcase
    end

    // A press clears the position even when a step lands in the same cycle.
    always_comb begin
        press_d = filt_c & ~center_prev_q;
        pos_d   = pos_q;
        if (press_d) begin
            pos_d = 8'd0;
        end else if (step_d) begin
            pos_d = (dir_d == DIR_CW) ? pos_q + 8'd1 : pos_q - 8'd1;
        end
    end

    assign STEP        = step_q;
    assign DIR         = dir_q;
    assign PRESS       = press_q;
    assign POS         = pos_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rotary_step_decoder.sv
// Bench for rotary_step_decoder with a short debounce: vector table, directed
// corner sequences and randomized encoder activity against a reference model.
module tb_rotary_step_decoder;
    import rotary_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       rot_a;
    logic       rot_b;
    logic       rot_center;
    logic       step;
    logic       dir;
    logic       press;
    logic [7:0] pos;
    rot_state_e dbg_state;

    rotary_step_decoder #(.DEBOUNCE_CYCLES(N)) dut (
        .CLK_IN(clk), .RST_IN(rst), .ROT_A(rot_a), .ROT_B(rot_b),
        .ROT_CENTER(rot_center), .STEP(step), .DIR(dir), .PRESS(press),
        .POS(pos), .dbg_state_o(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: filters as "N consecutive differing synchronized samples",
    // the detent decoder as a signed Gray-code displacement from the rest code.
    logic [2:0] m_hist[$];
    logic [2:0] m_filt;
    logic       m_cprev, m_err, m_dir, m_step, m_press;
    logic [1:0] m_last;
    logic [7:0] m_pos;
    int         m_d;

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < N + 2; i++) m_hist.push_back(3'b000);
        m_filt = 3'b000; m_cprev = 1'b0; m_err = 1'b0; m_dir = 1'b0;
        m_step = 1'b0; m_press = 1'b0; m_last = 2'b00; m_pos = 8'd0; m_d = 0;
    endtask

    task automatic model_edge();
        logic [1:0] ab;
        logic       stp, pr, all_diff;
        logic [2:0] dummy;
        int         di;
        if (rst) begin
            model_reset();
            return;
        end
        ab  = {m_filt[2], m_filt[1]};
        stp = 1'b0;
        if (m_err) begin
            if (ab == 2'b00) begin
                m_err = 1'b0; m_d = 0; m_last = 2'b00;
            end
        end else if (ab != m_last) begin
            di = (gidx(ab) - gidx(m_last) + 4) % 4;
            if (di == 1) m_d++;
            else if (di == 3) m_d--;
            else m_err = 1'b1;
            m_last = ab;
            if (!m_err && (m_d == 4 || m_d == -4)) begin
                stp = 1'b1; m_dir = (m_d == 4); m_d = 0;
            end
        end
        pr      = m_filt[0] && !m_cprev;
        m_cprev = m_filt[0];
        if (pr) m_pos = 8'd0;
        else if (stp) m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
        m_step  = stp;
        m_press = pr;
        m_hist.push_back({rot_a, rot_b, rot_center});
        for (int k = 0; k < 3; k++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= N; j++) if (m_hist[j][k] == m_filt[k]) all_diff = 1'b0;
            if (all_diff) m_filt[k] = ~m_filt[k];
        end
        dummy = m_hist.pop_front();
    endtask

    int         step_cnt  = 0;
    int         press_cnt = 0;
    int         st_chg    = 0;
    rot_state_e prev_st   = ST_IDLE;

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_edge();
            #2;
            chk("model_step", step, m_step);
            chk("model_press", press, m_press);
            chk("model_dir", dir, m_dir);
            chk("model_pos", pos, m_pos);
            if (step) step_cnt++;
            if (press) press_cnt++;
            if (dbg_state != prev_st) st_chg++;
            prev_st = dbg_state;
        end
    end

    task automatic seg(input logic a, input logic b, input logic c, input int cyc);
        rot_a = a; rot_b = b; rot_center = c;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic clear_counts();
        step_cnt = 0; press_cnt = 0; st_chg = 0;
    endtask

    typedef struct {
        logic a, b, c;
        int   cyc, steps, presses, pos;
        logic dir;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic a, b, c, input int steps, presses, p, input logic d);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.cyc = 10;
        v.steps = steps; v.presses = presses; v.pos = p; v.dir = d;
        vecs.push_back(v);
    endtask

    task automatic add_cw(input int p0, input logic d0);
        add(1, 0, 0, 0, 0, p0, d0); add(1, 1, 0, 0, 0, p0, d0);
        add(0, 1, 0, 0, 0, p0, d0); add(0, 0, 0, 1, 0, (p0 + 1) % 256, 1'b1);
    endtask

    task automatic add_ccw(input int p0, input logic d0);
        add(0, 1, 0, 0, 0, p0, d0); add(1, 1, 0, 0, 0, p0, d0);
        add(1, 0, 0, 0, 0, p0, d0); add(0, 0, 0, 1, 0, (p0 + 255) % 256, 1'b0);
    endtask

    task automatic wait_step(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #2;
            if (step) begin
                lat = k;
                break;
            end
        end
        chk(name, lat, 7);
    endtask

    logic [1:0] gray[4];
    int         lat;
    int         gi;

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        gray = '{2'b00, 2'b10, 2'b11, 2'b01};
        rst = 1'b1; rot_a = 1'b0; rot_b = 1'b0; rot_center = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step", step, 0); chk("rst_press", press, 0);
        chk("rst_dir", dir, 0);   chk("rst_pos", pos, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        add(0, 0, 0, 0, 0, 0, 0);
        add_cw(0, 0);
        add_ccw(1, 1);
        add_ccw(0, 0);
        add_cw(255, 0);
        add(1, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 0, 1); add(0, 0, 0, 1, 0, 1, 1);
        for (int i = 1; i < 5; i++) add_cw(i, 1);
        add(0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            clear_counts();
            seg(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cyc);
            chk($sformatf("vec%0d_steps", i), step_cnt, vecs[i].steps);
            chk($sformatf("vec%0d_presses", i), press_cnt, vecs[i].presses);
            chk($sformatf("vec%0d_pos", i), pos, vecs[i].pos);
            chk($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
        end

        // Bounce on A: only the final stable level gets through.
        clear_counts();
        for (int i = 0; i < 10; i++) seg((i % 2) == 0, 0, 0, 2);
        seg(1, 0, 0, 10);
        chk("bounce_state_changes", st_chg, 1);
        chk("bounce_state", dbg_state, ST_CW1);
        seg(0, 0, 0, 10);
        chk("bounce_back_idle", dbg_state, ST_IDLE);
        chk("bounce_steps", step_cnt, 0);

        clear_counts();
        seg(1, 1, 0, 10);
        chk("jump_err", dbg_state, ST_ERR);
        seg(0, 0, 0, 10);
        chk("jump_idle", dbg_state, ST_IDLE);
        chk("jump_steps", step_cnt, 0);
        chk("jump_pos", pos, 0);

        seg(1, 0, 0, 10); seg(1, 1, 0, 10); seg(0, 1, 0, 10);
        rot_a = 1'b0; rot_b = 1'b0;
        wait_step("cw_latency", lat);
        chk("cw_dir", dir, 1);
        chk("cw_pos", pos, 1);
        @(negedge clk);
        seg(0, 0, 0, 5);

        seg(1, 0, 0, 10); seg(1, 1, 0, 10); seg(0, 1, 0, 10);
        rot_a = 1'b0; rot_b = 1'b0; rot_center = 1'b1;
        wait_step("coinc_latency", lat);
        chk("coinc_press", press, 1);
        chk("coinc_pos", pos, 0);
        chk("coinc_dir", dir, 1);
        @(negedge clk);
        seg(0, 0, 0, 10);

        // Reset in the middle of a detent drops it.
        seg(1, 0, 0, 10); seg(1, 1, 0, 10);
        chk("mid_state_cw2", dbg_state, ST_CW2);
        rst = 1'b1;
        #2;
        chk("mid_rst_step", step, 0); chk("mid_rst_press", press, 0);
        chk("mid_rst_dir", dir, 0);   chk("mid_rst_pos", pos, 0);
        chk("mid_rst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        seg(1, 1, 0, 10); seg(0, 1, 0, 10); seg(0, 0, 0, 10);
        chk("mid_after_steps", step_cnt, 0);
        chk("mid_after_pos", pos, 0);
        chk("mid_after_state", dbg_state, ST_IDLE);

        gi = 0;
        for (int s = 0; s < 800; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) gi = (gi + 1) % 4;
            else if (r < 8) gi = (gi + 3) % 4;
            else if (r == 8) gi = (gi + 2) % 4;
            if ($urandom_range(0, 7) == 0) rot_center = ~rot_center;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            seg(gray[gi][1], gray[gi][0], rot_center, $urandom_range(1, 12));
        end
        seg(0, 0, 0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
